// File: rtl/network_bf_out_param.sv
// Butterfly output crossbar: routes the 2*NBF butterfly results onto NL lanes using a
// per-lane source select that is delayed SEL_DLY cycles to meet the butterfly data.
module network_bf_out_param #(
  parameter int DW      = 14,
  parameter int NBF     = 4,
  parameter int SEL_DLY = 7,
  localparam int NL     = 2 * NBF,
  localparam int SW     = (NL > 1) ? $clog2(NL) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NBF*DW-1:0] bf_upper,
  input  logic [NBF*DW-1:0] bf_lower,
  input  logic [NL*SW-1:0]  sel,
  input  logic              sel_valid,
  input  logic              bypass,
  input  logic              err_clr,
  output logic [NL*DW-1:0]  d,
  output logic              d_valid,
  output logic              err_dup
);

  logic [NL*SW-1:0]   sel_dly_q [SEL_DLY];
  logic [NL*SW-1:0]   sel_dly_d [SEL_DLY];
  logic [SEL_DLY-1:0] vld_dly_q, vld_dly_d;
  logic [SEL_DLY-1:0] byp_dly_q, byp_dly_d;
  logic [NL*DW-1:0]   d_q, d_d;
  logic               d_valid_q, d_valid_d;
  logic               err_dup_q, err_dup_d;

  logic [DW-1:0]      src [NL];
  logic [SW-1:0]      aligned_sel [NL];
  logic [SW-1:0]      lane_src;
  logic               aligned_vld, aligned_byp, dup_hit;

  // Control delay line; never stalls, so invalid issues travel through as bubbles.
  always_comb begin
    sel_dly_d[0] = sel;
    vld_dly_d    = '0;
    byp_dly_d    = '0;
    vld_dly_d[0] = sel_valid;
    byp_dly_d[0] = bypass;
    for (int j = 1; j < SEL_DLY; j++) begin
      sel_dly_d[j] = sel_dly_q[j-1];
      vld_dly_d[j] = vld_dly_q[j-1];
      byp_dly_d[j] = byp_dly_q[j-1];
    end
  end

  assign aligned_vld = vld_dly_q[SEL_DLY-1];
  assign aligned_byp = byp_dly_q[SEL_DLY-1];

  // Even source index = lower unit, odd = upper unit; NL is a power of two so every
  // select value names a real source.
  always_comb begin
    for (int k = 0; k < NBF; k++) begin
      src[2*k]   = bf_lower[k*DW +: DW];
      src[2*k+1] = bf_upper[k*DW +: DW];
    end
    for (int i = 0; i < NL; i++) begin
      aligned_sel[i] = sel_dly_q[SEL_DLY-1][i*SW +: SW];
    end
  end

  always_comb begin
    dup_hit = 1'b0;
    for (int a = 0; a < NL; a++) begin
      for (int b = a + 1; b < NL; b++) begin
        if (aligned_sel[a] == aligned_sel[b]) dup_hit = 1'b1;
      end
    end
  end

  always_comb begin
    d_d       = d_q;
    d_valid_d = aligned_vld;
    lane_src  = '0;
    if (aligned_vld) begin
      for (int i = 0; i < NL; i++) begin
        lane_src            = aligned_byp ? SW'(i) : aligned_sel[i];
        d_d[i*DW +: DW]     = src[lane_src];
      end
    end
    // A new duplicate outranks a coincident clear.
    err_dup_d = (aligned_vld && !aligned_byp && dup_hit) || (err_dup_q && !err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < SEL_DLY; j++) sel_dly_q[j] <= '0;
      vld_dly_q <= '0;
      byp_dly_q <= '0;
      d_q       <= '0;
      d_valid_q <= 1'b0;
      err_dup_q <= 1'b0;
    end else begin
      for (int j = 0; j < SEL_DLY; j++) sel_dly_q[j] <= sel_dly_d[j];
      vld_dly_q <= vld_dly_d;
      byp_dly_q <= byp_dly_d;
      d_q       <= d_d;
      d_valid_q <= d_valid_d;
      err_dup_q <= err_dup_d;
    end
  end

  assign d       = d_q;
  assign d_valid = d_valid_q;
  assign err_dup = err_dup_q;

endmodule

// File: tb/tb_network_bf_out_param.sv
// Bench for network_bf_out_param: default instance driven from per-cycle stimulus tables,
// plus NBF=1 and NBF=8 instances with SEL_DLY=1 under random traffic.
module tb_network_bf_out_param;
  localparam int DW = 14, NBF = 4, NL = 8, SW = 3, SEL_DLY = 7, MAXC = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NBF*DW-1:0] bf_upper, bf_lower;
  logic [NL*SW-1:0]  sel;
  logic              sel_valid, bypass, err_clr;
  logic [NL*DW-1:0]  d;
  logic              d_valid, err_dup;

  logic [DW-1:0]     a_up, a_lo;
  logic [1:0]        a_sel;
  logic              a_vld, a_byp, a_clr, a_dv, a_err;
  logic [2*DW-1:0]   a_d;
  logic [8*DW-1:0]   b_up, b_lo;
  logic [63:0]       b_sel;
  logic              b_vld, b_byp, b_clr, b_dv, b_err;
  logic [16*DW-1:0]  b_d;

  int n_cmp = 0, n_bad = 0;

  logic [SW-1:0]     st_sel [MAXC][NL];
  bit                st_vld [MAXC], st_byp [MAXC], st_clr [MAXC], st_rst [MAXC];
  logic [DW-1:0]     st_up [MAXC][NBF], st_lo [MAXC][NBF];
  logic [NL*DW-1:0]  ob_d [MAXC], ex_d [MAXC];
  logic              ob_vld [MAXC], ob_err [MAXC], ex_vld [MAXC], ex_err [MAXC];

  network_bf_out_param u_dut (
    .clk(clk), .rst(rst), .bf_upper(bf_upper), .bf_lower(bf_lower), .sel(sel),
    .sel_valid(sel_valid), .bypass(bypass), .err_clr(err_clr),
    .d(d), .d_valid(d_valid), .err_dup(err_dup));

  network_bf_out_param #(.DW(DW), .NBF(1), .SEL_DLY(1)) u_n1 (
    .clk(clk), .rst(rst), .bf_upper(a_up), .bf_lower(a_lo), .sel(a_sel),
    .sel_valid(a_vld), .bypass(a_byp), .err_clr(a_clr),
    .d(a_d), .d_valid(a_dv), .err_dup(a_err));

  network_bf_out_param #(.DW(DW), .NBF(8), .SEL_DLY(1)) u_n8 (
    .clk(clk), .rst(rst), .bf_upper(b_up), .bf_lower(b_lo), .sel(b_sel),
    .sel_valid(b_vld), .bypass(b_byp), .err_clr(b_clr),
    .d(b_d), .d_valid(b_dv), .err_dup(b_err));

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      st_vld[c] = 0; st_byp[c] = 0; st_clr[c] = 0; st_rst[c] = 0;
      for (int i = 0; i < NL; i++) st_sel[c][i] = SW'($urandom);
      for (int k = 0; k < NBF; k++) begin
        st_up[c][k] = DW'($urandom);
        st_lo[c][k] = DW'($urandom);
      end
    end
  endtask

  task automatic spec_data(input int c);
    for (int k = 0; k < NBF; k++) begin
      st_up[c][k] = DW'('h100 + k);
      st_lo[c][k] = DW'('h200 + k);
    end
  endtask

  // Resets the DUT (with junk issues presented during reset), then plays cycles 0..n-1.
  // Outputs recorded for cycle c are those visible just after edge c.
  task automatic run(input int n);
    rst = 1'b1;
    for (int r = 0; r < 3; r++) begin
      sel_valid = 1'b1; bypass = 1'b0; err_clr = 1'b1; sel = 24'($urandom);
      bf_upper = 56'({$urandom, $urandom}); bf_lower = 56'({$urandom, $urandom});
      @(posedge clk); #1;
    end
    rst = 1'b0; sel_valid = 1'b0; err_clr = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      ob_d[c] = d; ob_vld[c] = d_valid; ob_err[c] = err_dup;
      rst = st_rst[c]; sel_valid = st_vld[c]; bypass = st_byp[c]; err_clr = st_clr[c];
      for (int i = 0; i < NL; i++) sel[i*SW +: SW] = st_sel[c][i];
      for (int k = 0; k < NBF; k++) begin
        bf_upper[k*DW +: DW] = st_up[c][k];
        bf_lower[k*DW +: DW] = st_lo[c][k];
      end
    end
    rst = 1'b0; sel_valid = 1'b0; err_clr = 1'b0;
  endtask

  // Reference: the word seen in cycle c comes from the issue made in cycle c-1-SEL_DLY
  // and the butterfly data presented in cycle c-1, unless a reset cycle intervened.
  task automatic model(input int n);
    logic [NL*DW-1:0] md;
    logic mv, me;
    int p, j, s;
    bit ok, dup;
    md = '0; me = 1'b0;
    for (int c = 0; c < n; c++) begin
      mv = 1'b0;
      if (c > 0) begin
        p = c - 1;
        if (st_rst[p]) begin
          md = '0; me = 1'b0;
        end else begin
          j = p - SEL_DLY;
          ok = (j >= 0) && st_vld[j];
          for (int q = j; ok && q < p; q++) if (st_rst[q]) ok = 0;
          dup = 0;
          if (ok) begin
            mv = 1'b1;
            for (int i = 0; i < NL; i++) begin
              s = st_byp[j] ? i : int'(st_sel[j][i]);
              md[i*DW +: DW] = (s % 2 == 1) ? st_up[p][s/2] : st_lo[p][s/2];
            end
            if (!st_byp[j])
              for (int a = 0; a < NL; a++)
                for (int b = a + 1; b < NL; b++)
                  if (st_sel[j][a] == st_sel[j][b]) dup = 1;
          end
          me = dup | (me & ~st_clr[p]);
        end
      end
      ex_d[c] = md; ex_vld[c] = mv; ex_err[c] = me;
    end
  endtask

  task automatic test_reset();
    clear_stim();
    run(12);
    model(12);
    n_cmp++;
    if (ob_d[0] !== '0 || ob_vld[0] !== 1'b0 || ob_err[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got d=%h v=%b e=%b, want all zero", ob_d[0], ob_vld[0], ob_err[0]);
    end
    for (int c = 0; c < 12; c++) begin
      n_cmp++;
      if (ob_d[c] !== ex_d[c] || ob_vld[c] !== ex_vld[c] || ob_err[c] !== ex_err[c]) begin
        n_bad++;
        $display("FAIL reset_idle c%0d: got d=%h v=%b e=%b, want d=%h v=%b e=%b",
                 c, ob_d[c], ob_vld[c], ob_err[c], ex_d[c], ex_vld[c], ex_err[c]);
      end
    end
  endtask

  task automatic test_routing();
    int s;
    logic [DW-1:0] want;
    clear_stim();
    st_vld[0] = 1;
    for (int i = 0; i < NL; i++) st_sel[0][i] = SW'(7 - i);
    spec_data(7);
    for (int c = 12; c < 26; c++) st_vld[c] = ($urandom_range(3) != 0);
    run(36);
    model(36);
    for (int i = 0; i < NL; i++) begin
      s = 7 - i;
      want = (s % 2 == 1) ? DW'('h100 + s / 2) : DW'('h200 + s / 2);
      n_cmp++;
      if (ob_d[8][i*DW +: DW] !== want) begin
        n_bad++;
        $display("FAIL reverse_lane%0d: got %h, want %h", i, ob_d[8][i*DW +: DW], want);
      end
    end
    n_cmp++;
    if (ob_vld[7] !== 1'b0 || ob_vld[8] !== 1'b1 || ob_vld[9] !== 1'b0) begin
      n_bad++;
      $display("FAIL reverse_pulse: got v7..9=%b%b%b, want 010", ob_vld[7], ob_vld[8], ob_vld[9]);
    end
    for (int c = 0; c < 36; c++) begin
      n_cmp++;
      if (ob_d[c] !== ex_d[c] || ob_vld[c] !== ex_vld[c] || ob_err[c] !== ex_err[c]) begin
        n_bad++;
        $display("FAIL routing c%0d: got d=%h v=%b e=%b, want d=%h v=%b e=%b",
                 c, ob_d[c], ob_vld[c], ob_err[c], ex_d[c], ex_vld[c], ex_err[c]);
      end
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] want;
    clear_stim();
    st_vld[0] = 1; st_byp[0] = 1;
    for (int i = 0; i < NL; i++) st_sel[0][i] = SW'(5);
    spec_data(7);
    for (int c = 5; c < 20; c++) begin
      st_vld[c] = 1; st_byp[c] = 1;
      for (int i = 0; i < NL; i++) st_sel[c][i] = SW'($urandom_range(1));
    end
    run(32);
    model(32);
    for (int i = 0; i < NL; i++) begin
      want = (i % 2 == 1) ? DW'('h100 + i / 2) : DW'('h200 + i / 2);
      n_cmp++;
      if (ob_d[8][i*DW +: DW] !== want) begin
        n_bad++;
        $display("FAIL bypass_lane%0d: got %h, want %h", i, ob_d[8][i*DW +: DW], want);
      end
    end
    for (int c = 0; c < 32; c++) begin
      n_cmp++;
      if (ob_d[c] !== ex_d[c] || ob_vld[c] !== ex_vld[c] || ob_err[c] !== 1'b0) begin
        n_bad++;
        $display("FAIL bypass c%0d: got d=%h v=%b e=%b, want d=%h v=%b e=0",
                 c, ob_d[c], ob_vld[c], ob_err[c], ex_d[c], ex_vld[c]);
      end
    end
  endtask

  task automatic test_dup();
    int dsel [NL];
    dsel = '{2, 0, 1, 2, 3, 4, 5, 6};
    clear_stim();
    for (int i = 0; i < NL; i++) begin
      st_sel[0][i]  = SW'(dsel[i]);
      st_sel[31][i] = SW'(dsel[i]);
    end
    st_vld[0] = 1; st_vld[31] = 1;
    spec_data(7);
    st_clr[29] = 1;
    st_clr[38] = 1;
    run(42);
    model(42);
    n_cmp++;
    if (ob_d[8][0 +: DW] !== 14'h201 || ob_d[8][3*DW +: DW] !== 14'h201) begin
      n_bad++;
      $display("FAIL dup_route: got d0=%h d3=%h, want 201 201", ob_d[8][0 +: DW], ob_d[8][3*DW +: DW]);
    end
    n_cmp++;
    if (ob_err[7] !== 1'b0 || ob_err[8] !== 1'b1 || ob_err[28] !== 1'b1 ||
        ob_err[30] !== 1'b0 || ob_err[38] !== 1'b0 || ob_err[39] !== 1'b1) begin
      n_bad++;
      $display("FAIL dup_flag: got e7,8,28,30,38,39=%b%b%b%b%b%b, want 011001",
               ob_err[7], ob_err[8], ob_err[28], ob_err[30], ob_err[38], ob_err[39]);
    end
    for (int c = 0; c < 42; c++) begin
      n_cmp++;
      if (ob_d[c] !== ex_d[c] || ob_vld[c] !== ex_vld[c] || ob_err[c] !== ex_err[c]) begin
        n_bad++;
        $display("FAIL dup c%0d: got d=%h v=%b e=%b, want d=%h v=%b e=%b",
                 c, ob_d[c], ob_vld[c], ob_err[c], ex_d[c], ex_vld[c], ex_err[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int perm [NL];
    int t, r;
    for (int pass = 0; pass < 2; pass++) begin
      clear_stim();
      for (int c = 0; c < 8; c++) begin
        for (int i = 0; i < NL; i++) perm[i] = i;
        for (int i = NL - 1; i > 0; i--) begin
          r = $urandom_range(i); t = perm[i]; perm[i] = perm[r]; perm[r] = t;
        end
        for (int i = 0; i < NL; i++) st_sel[c][i] = SW'(perm[i]);
        st_vld[c] = (pass == 0) || (c != 3);
      end
      run(20);
      model(20);
      for (int c = 8; c < 17; c++) begin
        n_cmp++;
        if (ob_vld[c] !== ((c < 16) && !(pass == 1 && c == 11))) begin
          n_bad++;
          $display("FAIL b2b_valid p%0d c%0d: got %b", pass, c, ob_vld[c]);
        end
      end
      if (pass == 1) begin
        n_cmp++;
        if (ob_d[11] !== ex_d[10]) begin
          n_bad++;
          $display("FAIL bubble_hold: got %h, want %h", ob_d[11], ex_d[10]);
        end
      end
      for (int c = 0; c < 20; c++) begin
        n_cmp++;
        if (ob_d[c] !== ex_d[c] || ob_vld[c] !== ex_vld[c] || ob_err[c] !== ex_err[c]) begin
          n_bad++;
          $display("FAIL b2b p%0d c%0d: got d=%h v=%b e=%b, want d=%h v=%b e=%b",
                   pass, c, ob_d[c], ob_vld[c], ob_err[c], ex_d[c], ex_vld[c], ex_err[c]);
        end
      end
    end
  endtask

  task automatic test_reset_flight();
    clear_stim();
    st_vld[0] = 1;
    st_rst[4] = 1;
    st_vld[6] = 1;
    run(18);
    model(18);
    for (int c = 0; c < 14; c++) begin
      n_cmp++;
      if (ob_vld[c] !== 1'b0 || ob_d[c] !== '0) begin
        n_bad++;
        $display("FAIL flight_discard c%0d: got v=%b d=%h, want v=0 d=0", c, ob_vld[c], ob_d[c]);
      end
    end
    n_cmp++;
    if (ob_vld[14] !== 1'b1 || ob_d[14] !== ex_d[14]) begin
      n_bad++;
      $display("FAIL flight_fresh: got v=%b d=%h, want v=1 d=%h", ob_vld[14], ob_d[14], ex_d[14]);
    end
  endtask

  // Latency-2 instances: the word seen in cycle c comes from the issue of cycle c-2
  // and the data of cycle c-1.
  task automatic test_param_sweep();
    logic [1:0]        ah_sel [32];
    logic [DW-1:0]     ah_up [32], ah_lo [32];
    bit                ah_v [32], ah_b [32], ah_c [32];
    logic [63:0]       bh_sel [32];
    logic [8*DW-1:0]   bh_up [32], bh_lo [32];
    bit                bh_v [32], bh_b [32], bh_c [32];
    logic [2*DW-1:0]   ea_d;
    logic [16*DW-1:0]  eb_d;
    logic              ea_v, ea_e, eb_v, eb_e;
    bit                dup;
    int                s;
    rst = 1'b1;
    a_vld = 1'b1; b_vld = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0; a_vld = 1'b0; b_vld = 1'b0; a_clr = 1'b0; b_clr = 1'b0;
    ea_d = '0; eb_d = '0; ea_e = 1'b0; eb_e = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      ea_v = 1'b0; eb_v = 1'b0;
      if (c >= 2 && ah_v[c-2]) begin
        ea_v = 1'b1;
        for (int i = 0; i < 2; i++) begin
          s = ah_b[c-2] ? i : int'(ah_sel[c-2][i]);
          ea_d[i*DW +: DW] = (s == 1) ? ah_up[c-1] : ah_lo[c-1];
        end
      end
      dup = (c >= 2) && ah_v[c-2] && !ah_b[c-2] && (ah_sel[c-2][0] == ah_sel[c-2][1]);
      if (c >= 1) ea_e = dup | (ea_e & ~ah_c[c-1]);
      if (c >= 2 && bh_v[c-2]) begin
        eb_v = 1'b1;
        for (int i = 0; i < 16; i++) begin
          s = bh_b[c-2] ? i : int'(bh_sel[c-2][i*4 +: 4]);
          eb_d[i*DW +: DW] = (s % 2 == 1) ? bh_up[c-1][(s/2)*DW +: DW] : bh_lo[c-1][(s/2)*DW +: DW];
        end
      end
      dup = 0;
      if (c >= 2 && bh_v[c-2] && !bh_b[c-2])
        for (int a = 0; a < 16; a++)
          for (int b = a + 1; b < 16; b++)
            if (bh_sel[c-2][a*4 +: 4] == bh_sel[c-2][b*4 +: 4]) dup = 1;
      if (c >= 1) eb_e = dup | (eb_e & ~bh_c[c-1]);
      n_cmp++;
      if (a_d !== ea_d || a_dv !== ea_v || a_err !== ea_e) begin
        n_bad++;
        $display("FAIL nbf1 c%0d: got d=%h v=%b e=%b, want d=%h v=%b e=%b", c, a_d, a_dv, a_err, ea_d, ea_v, ea_e);
      end
      n_cmp++;
      if (b_d !== eb_d || b_dv !== eb_v || b_err !== eb_e) begin
        n_bad++;
        $display("FAIL nbf8 c%0d: got d=%h v=%b e=%b, want d=%h v=%b e=%b", c, b_d, b_dv, b_err, eb_d, eb_v, eb_e);
      end
      ah_v[c] = (c == 0) || ($urandom_range(3) != 0); ah_b[c] = ($urandom_range(3) == 0);
      ah_c[c] = ($urandom_range(7) == 0); ah_sel[c] = 2'($urandom);
      ah_up[c] = DW'($urandom); ah_lo[c] = DW'($urandom);
      bh_v[c] = (c == 0) || ($urandom_range(3) != 0); bh_b[c] = ($urandom_range(3) == 0);
      bh_c[c] = ($urandom_range(7) == 0); bh_sel[c] = {$urandom, $urandom};
      bh_up[c] = 112'({$urandom, $urandom, $urandom, $urandom});
      bh_lo[c] = 112'({$urandom, $urandom, $urandom, $urandom});
      a_vld = ah_v[c]; a_byp = ah_b[c]; a_clr = ah_c[c]; a_sel = ah_sel[c]; a_up = ah_up[c]; a_lo = ah_lo[c];
      b_vld = bh_v[c]; b_byp = bh_b[c]; b_clr = bh_c[c]; b_sel = bh_sel[c]; b_up = bh_up[c]; b_lo = bh_lo[c];
    end
    a_vld = 1'b0; b_vld = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel_valid = 1'b0; bypass = 1'b0; err_clr = 1'b0; sel = '0;
    bf_upper = '0; bf_lower = '0;
    a_up = '0; a_lo = '0; a_sel = '0; a_vld = 1'b0; a_byp = 1'b0; a_clr = 1'b0;
    b_up = '0; b_lo = '0; b_sel = '0; b_vld = 1'b0; b_byp = 1'b0; b_clr = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_routing();
    test_bypass();
    test_dup();
    test_back_to_back();
    test_reset_flight();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
